// File: rtl/dataflow_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dataflow_pkg
// Brief    : Shared state encoding and counter sizing for dataflow_gate_n.
// Revision : 1.0 - initial release
// ============================================================================
package dataflow_pkg;

    typedef enum logic [0:0] {
        S_SKIP    = 1'b0,
        S_FORWARD = 1'b1
    } gate_state_t;

    function automatic int cnt_width(input int skip);
        return (skip < 1) ? 1 : $clog2(skip + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dataflow_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : dataflow_skid_buf
// Brief    : Two-entry skid buffer; registered valid/data, full throughput.
// Revision : 1.0 - initial release
// ============================================================================
module dataflow_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    assign o_ready = ~r_skid_valid;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (!r_skid_valid) begin
            if (!r_valid || i_ready) begin
                r_valid <= i_valid;
                r_data  <= i_valid ? i_data : '0;
            end else if (i_valid) begin
                // output stalled: park the accepted word in the skid slot
                r_skid_valid <= 1'b1;
                r_skid_data  <= i_data;
            end
        end else if (i_ready) begin
            r_valid      <= 1'b1;
            r_data       <= r_skid_data;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dataflow_gate_n.sv
`default_nettype none
// ============================================================================
// Module   : dataflow_gate_n
// Brief    : Drops the first SKIP condition tokens, then joins NUM_VAL value
//            lanes with the condition stream and eagerly forks the result.
//            Define DATAFLOW_GATE_N_OUTREG_EN to add a skid buffer per output.
// Revision : 1.0 - initial release
// ============================================================================
module dataflow_gate_n
    import dataflow_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_VAL = 2,
    parameter int SKIP    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     restart,
    input  logic [NUM_VAL-1:0]       bv_valid,
    output logic [NUM_VAL-1:0]       bv_ready,
    input  logic [NUM_VAL*WIDTH-1:0] bv_data,
    input  logic                     bc_valid,
    output logic                     bc_ready,
    input  logic                     bc_data,
    output logic [NUM_VAL-1:0]       av_valid,
    input  logic [NUM_VAL-1:0]       av_ready,
    output logic [NUM_VAL*WIDTH-1:0] av_data,
    output logic                     ac_valid,
    input  logic                     ac_ready,
    output logic                     ac_data,
    output logic                     skipping
);

    localparam int                NOUT     = NUM_VAL + 1;
    localparam int                CW       = cnt_width(SKIP);
    localparam gate_state_t       ST_INIT  = (SKIP == 0) ? S_FORWARD : S_SKIP;
    localparam logic [CW-1:0]     CNT_INIT = CW'(SKIP);

    gate_state_t       r_state;
    logic [CW-1:0]     r_cnt;
    logic [NOUT-1:0]   r_done;

    logic              w_fwd;
    logic              w_join;
    logic              w_fire;
    logic [NOUT-1:0]   w_out_valid;
    logic [NOUT-1:0]   w_out_ready;
    logic [NOUT-1:0]   w_acc;

    // restart blocks the join so nothing is accepted or consumed that cycle
    assign w_fwd       = (r_state == S_FORWARD);
    assign w_join      = w_fwd & ~restart & (&bv_valid) & bc_valid;
    assign w_out_valid = {NOUT{w_join}} & ~r_done;
    assign w_acc       = w_out_valid & w_out_ready;
    assign w_fire      = w_join & (&(r_done | w_acc));

    assign bv_ready = {NUM_VAL{w_fire}};
    assign bc_ready = w_fwd ? w_fire : ~restart;
    assign skipping = ~w_fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= CNT_INIT;
            r_done  <= '0;
        end else if (restart) begin
            r_state <= ST_INIT;
            r_cnt   <= CNT_INIT;
            r_done  <= '0;
        end else if (r_state == S_SKIP) begin
            if (bc_valid) begin
                if (r_cnt == CW'(1)) begin
                    r_state <= S_FORWARD;
                end
                r_cnt <= r_cnt - CW'(1);
            end
        end else if (w_fire) begin
            r_done <= '0;
        end else begin
            r_done <= r_done | w_acc;
        end
    end

`ifdef DATAFLOW_GATE_N_OUTREG_EN
    for (genvar k = 0; k < NUM_VAL; k++) begin : g_lane
        dataflow_skid_buf #(.WIDTH(WIDTH)) u_skid (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_out_valid[k]),
            .o_ready (w_out_ready[k]),
            .i_data  (bv_data[k*WIDTH +: WIDTH]),
            .o_valid (av_valid[k]),
            .i_ready (av_ready[k]),
            .o_data  (av_data[k*WIDTH +: WIDTH])
        );
    end

    dataflow_skid_buf #(.WIDTH(1)) u_skid_cond (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_out_valid[NUM_VAL]),
        .o_ready (w_out_ready[NUM_VAL]),
        .i_data  (bc_data),
        .o_valid (ac_valid),
        .i_ready (ac_ready),
        .o_data  (ac_data)
    );
`else
    for (genvar k = 0; k < NUM_VAL; k++) begin : g_lane
        assign w_out_ready[k]             = av_ready[k];
        assign av_valid[k]                = w_out_valid[k];
        assign av_data[k*WIDTH +: WIDTH]  = w_out_valid[k] ? bv_data[k*WIDTH +: WIDTH] : '0;
    end

    assign w_out_ready[NUM_VAL] = ac_ready;
    assign ac_valid             = w_out_valid[NUM_VAL];
    assign ac_data              = w_out_valid[NUM_VAL] & bc_data;
`endif

endmodule
`default_nettype wire
